div_8_bit_seq: RTL and testbench

Sequential 8-bit unsigned restoring divider and the direct consumer of `sub_8_bit`. It produces one quotient bit per clock from a trial subtraction on a single `sub_8_bit` instance. Operands arrive and results leave on valid/ready handshakes. It sits downstream of the arithmetic datapath and feeds the result bus.

---
 rtl/div_8_bit_seq_pkg.sv | 13 +
 rtl/sub_8_bit.sv | 18 +
 rtl/div_8_bit_seq.sv | 102 ++++++++++
 tb/tb_div_8_bit_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_8_bit_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int ITER  = 8;
    localparam int CNT_W = 3;

endpackage

// File: rtl/sub_8_bit.sv
// 8-bit subtractor: sub = a - b - cin mod 256, cout = 1 on borrow.
// Purely combinational; no handshake.
module sub_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sub,
    output logic       cout
);

    logic [8:0] sum;

    // Two's-complement add; a missing carry-out means the subtraction borrowed.
    assign sum  = {1'b0, a} + {1'b0, ~b} + {8'b0, ~cin};
    assign sub  = sum[7:0];
    assign cout = ~sum[8];

endmodule

// File: rtl/div_8_bit_seq.sv
// Restoring 8-bit unsigned divider, one quotient bit per clock; result valid 8 cycles after accept.
// Result held in DONE until out_ready; in_ready only in IDLE, so operations never overlap.
module div_8_bit_seq
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_zero
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [7:0]       r_q;
    logic [7:0]       q_q;
    logic [7:0]       d_q;
    logic [CNT_W-1:0] cnt;
    logic             dz_q;

    logic             ovf;
    logic [7:0]       s;
    logic [7:0]       t;
    logic             bo;
    logic             take;
    logic             last;
    logic [7:0]       r_step;
    logic [7:0]       q_step;

    // Shifted partial remainder is 9 bits wide: {ovf, s}. With ovf set it
    // always exceeds the divisor, so the truncated difference is exact.
    assign ovf    = r_q[7];
    assign s      = {r_q[6:0], q_q[7]};
    assign take   = ovf | ~bo;
    assign r_step = take ? t : s;
    assign q_step = {q_q[6:0], take};
    assign last   = (cnt == CNT_W'(ITER - 1));

    sub_8_bit u_sub (
        .a    (s),
        .b    (d_q),
        .cin  (1'b0),
        .sub  (t),
        .cout (bo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            dz_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_q  <= '0;
                        q_q  <= dividend;
                        d_q  <= divisor;
                        cnt  <= '0;
                        dz_q <= (divisor == 8'd0);
                    end
                end
                CALC: begin
                    r_q <= r_step;
                    q_q <= q_step;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_8_bit_seq.sv
// Directed and random checks of the sequential divider against hand-computed values.
module tb_div_8_bit_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_8_bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Runs one operation; returns at the falling edge where out_valid is first seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output int accept, output int rise, output bit ok);
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_in_ready: in_ready=%b required 1 (op %0d/%0d)", in_ready, a, b);
            ok = 1'b0;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        accept   = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        rise = cyc;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_out_valid: out_valid=%b required 1 (op %0d/%0d)", out_valid, a, b);
            ok = 1'b0;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 8'd0;
        divisor   = 8'd0;
        #12;
        n_checks++; if (in_ready  !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (quotient  !== 8'd0)  begin n_fail++; $display("FAIL reset_quotient: got %0d required 0", quotient); end
        n_checks++; if (remainder !== 8'd0)  begin n_fail++; $display("FAIL reset_remainder: got %0d required 0", remainder); end
        n_checks++; if (div_zero  !== 1'b0)  begin n_fail++; $display("FAIL reset_div_zero: got %b required 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic [7:0] eq [6];
        logic [7:0] er [6];
        logic       ez [6];
        logic [7:0] q, r;
        logic       dz;
        int         acc, rise;
        bit         ok;
        va = '{8'd100, 8'd255, 8'd255, 8'd5, 8'd0,   8'd200};
        vb = '{8'd7,   8'd200, 8'd1,   8'd9, 8'd0,   8'd0};
        eq = '{8'd14,  8'd1,   8'd255, 8'd0, 8'hFF,  8'hFF};
        er = '{8'd2,   8'd55,  8'd0,   8'd5, 8'd0,   8'd200};
        ez = '{1'b0,   1'b0,   1'b0,   1'b0, 1'b1,   1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], q, r, dz, acc, rise, ok);
            n_checks++; if (q !== eq[i]) begin n_fail++; $display("FAIL dir_quotient %0d/%0d: got %0d required %0d", va[i], vb[i], q, eq[i]); end
            n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL dir_remainder %0d/%0d: got %0d required %0d", va[i], vb[i], r, er[i]); end
            n_checks++; if (dz !== ez[i]) begin n_fail++; $display("FAIL dir_div_zero %0d/%0d: got %b required %b", va[i], vb[i], dz, ez[i]); end
            n_checks++; if (rise - acc !== 8) begin n_fail++; $display("FAIL dir_latency %0d/%0d: got %0d required 8", va[i], vb[i], rise - acc); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] q, r;
        logic       dz;
        int         acc, rise;
        bit         ok;
        out_ready = 1'b0;
        run_op(8'd100, 8'd7, q, r, dz, acc, rise, ok);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            dividend = 8'd33 + 8'(i);
            divisor  = 8'd3;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b required 1", i, out_valid); end
            n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL bp_quotient[%0d]: got %0d required 14", i, quotient); end
            n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL bp_remainder[%0d]: got %0d required 2", i, remainder); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
        n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL bp_idle_quotient: got %0d required 14", quotient); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_stray_accept: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] q, r;
        logic       dz;
        int         acc, rise;
        bit         ok;
        out_ready = 1'b1;
        dividend  = 8'd100;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        n_checks++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL mid_quotient: got %0d required 0", quotient); end
        n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL mid_remainder: got %0d required 0", remainder); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL mid_div_zero: got %b required 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd50, 8'd6, q, r, dz, acc, rise, ok);
        n_checks++; if (q !== 8'd8) begin n_fail++; $display("FAIL post_reset_quotient: got %0d required 8", q); end
        n_checks++; if (r !== 8'd2) begin n_fail++; $display("FAIL post_reset_remainder: got %0d required 2", r); end
        n_checks++; if (rise - acc !== 8) begin n_fail++; $display("FAIL post_reset_latency: got %0d required 8", rise - acc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, q, r, xq, xr;
        logic       dz;
        int         acc, rise, prev_rise;
        bit         ok;
        out_ready = 1'b1;
        prev_rise = -1;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (b == 8'd0) begin
                xq = 8'hFF;
                xr = a;
            end else begin
                xq = a / b;
                xr = a % b;
            end
            run_op(a, b, q, r, dz, acc, rise, ok);
            n_checks++; if (q !== xq) begin n_fail++; $display("FAIL b2b_quotient %0d/%0d: got %0d required %0d", a, b, q, xq); end
            n_checks++; if (r !== xr) begin n_fail++; $display("FAIL b2b_remainder %0d/%0d: got %0d required %0d", a, b, r, xr); end
            n_checks++; if (dz !== (b == 8'd0)) begin n_fail++; $display("FAIL b2b_div_zero %0d/%0d: got %b required %b", a, b, dz, (b == 8'd0)); end
            n_checks++; if (rise - acc !== 8) begin n_fail++; $display("FAIL b2b_latency %0d/%0d: got %0d required 8", a, b, rise - acc); end
            if (prev_rise >= 0) begin
                n_checks++;
                if (acc - prev_rise !== 2) begin n_fail++; $display("FAIL b2b_spacing op %0d: accept %0d cycles after previous out_valid, required 2", i, acc - prev_rise); end
            end
            prev_rise = rise;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
